// File: rtl/pa_riscv.sv
// ---------------------------------------------------------------------------
// pa_riscv
// Shared definitions for the multicycle RV32I core control path.
//   - RV32I opcode constants for the supported instruction classes
//   - st_main_t: states of the main control FSM
//   - enums for ALU operation class, ALU control code, result select,
//     ALU operand selects and immediate format select
// No ports; imported by the controller, its interface and the ALU decoder.
// ---------------------------------------------------------------------------
package pa_riscv;

  localparam logic [6:0] LW         = 7'b0000011;
  localparam logic [6:0] SW         = 7'b0100011;
  localparam logic [6:0] R_TYPE_ALU = 7'b0110011;
  localparam logic [6:0] I_TYPE_ALU = 7'b0010011;
  localparam logic [6:0] B_TYPE     = 7'b1100011;
  localparam logic [6:0] JAL        = 7'b1101111;

  // State labels carry an S_ prefix so S_JAL does not collide with the
  // JAL opcode constant in this package.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } st_main_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_RDATA  = 2'b01,
    RES_ALURES = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the main controller and the datapath.
//   i_opcode/i_funct3/i_funct7b5 : instruction fields from the IR
//   i_zero                       : ALU zero flag, current cycle
//   o_*                          : datapath enables and selects
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;

  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;

  logic       o_pcWrite;
  logic       o_adrSrc;
  logic       o_memWrite;
  logic       o_irWrite;
  logic [1:0] o_resultSrc;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_immSrc;
  logic [2:0] o_aluControl;
  logic       o_regWrite;
  logic       o_illegal;

  modport master (
    input  i_opcode, i_funct3, i_funct7b5, i_zero,
    output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
           o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_regWrite,
           o_illegal
  );

  modport slave (
    output i_opcode, i_funct3, i_funct7b5, i_zero,
    input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
           o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_regWrite,
           o_illegal
  );

endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   i_aluOp      : operation class from the main FSM (add / sub / funct)
//   i_funct3     : instr[14:12]
//   i_opcodeB5   : instr[5], separates R-type from I-type
//   i_funct7b5   : instr[30]
//   o_aluControl : ALU function code
// ---------------------------------------------------------------------------
module alu_decoder
  import pa_riscv::*;
(
  input  alu_op_t    i_aluOp,
  input  logic [2:0] i_funct3,
  input  logic       i_opcodeB5,
  input  logic       i_funct7b5,
  output alu_ctrl_t  o_aluControl
);

  // Subtract only for R-type with instr[30] set; addi keeps instr[30] as
  // part of its immediate, so it must stay an add.
  always_comb begin
    o_aluControl = ALU_ADD;
    case (i_aluOp)
      ALUOP_ADD: o_aluControl = ALU_ADD;
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_aluControl = (i_opcodeB5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_aluControl = ALU_SLT;
          3'b110:  o_aluControl = ALU_OR;
          3'b111:  o_aluControl = ALU_AND;
          default: o_aluControl = ALU_ADD;
        endcase
      end
      default: o_aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset; forces every output to 0
//   bus   : multicycle_controller_if.master (instruction fields, zero flag,
//           all datapath enables and selects, illegal-opcode pulse)
// Outputs are combinational from the current state and the opcode.
// ---------------------------------------------------------------------------
module multicycle_controller
  import pa_riscv::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  multicycle_controller_if.master       bus
);

  st_main_t    state_q, state_d;
  alu_op_t     aluOp;
  alu_ctrl_t   aluControl;
  result_src_t resultSrc;
  alu_src_a_t  aluSrcA;
  alu_src_b_t  aluSrcB;
  imm_src_t    immDec, immSrc;
  logic        pcUpdate, branch;
  logic        adrSrc, memWrite, irWrite, regWrite, illegal;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    immDec = IMM_I;
    case (bus.i_opcode)
      SW:      immDec = IMM_S;
      B_TYPE:  immDec = IMM_B;
      JAL:     immDec = IMM_J;
      default: immDec = IMM_I;
    endcase
  end

  // Next state and per-state controls. Everything stays at its zero default
  // while reset is high, so an abandoned instruction cannot write anything.
  always_comb begin
    state_d   = state_q;
    aluOp     = ALUOP_ADD;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RD2;
    immSrc    = IMM_I;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    illegal   = 1'b0;
    if (!i_rst) begin
      immSrc = immDec;
      case (state_q)
        S_FETCH: begin
          irWrite   = 1'b1;
          aluSrcB   = SRCB_FOUR;
          resultSrc = RES_ALURES;
          pcUpdate  = 1'b1;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          aluSrcA = SRCA_OLDPC;
          aluSrcB = SRCB_IMM;
          case (bus.i_opcode)
            LW, SW:     state_d = S_MEMADR;
            R_TYPE_ALU: state_d = S_EXECUTER;
            I_TYPE_ALU: state_d = S_EXECUTEI;
            B_TYPE:     state_d = S_BEQ;
            JAL:        state_d = S_JAL;
            default: begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          aluSrcA = SRCA_RD1;
          aluSrcB = SRCB_IMM;
          state_d = (bus.i_opcode == LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          adrSrc  = 1'b1;
          state_d = S_MEMWB;
        end
        S_MEMWB: begin
          resultSrc = RES_RDATA;
          regWrite  = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEMWRITE: begin
          adrSrc   = 1'b1;
          memWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_EXECUTER: begin
          aluSrcA = SRCA_RD1;
          aluOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_EXECUTEI: begin
          aluSrcA = SRCA_RD1;
          aluSrcB = SRCB_IMM;
          aluOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          regWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_BEQ: begin
          aluSrcA = SRCA_RD1;
          aluOp   = ALUOP_SUB;
          branch  = 1'b1;
          state_d = S_FETCH;
        end
        S_JAL: begin
          aluSrcA  = SRCA_OLDPC;
          aluSrcB  = SRCB_FOUR;
          pcUpdate = 1'b1;
          state_d  = S_ALUWB;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  alu_decoder u_aluDecoder (
    .i_aluOp      (aluOp),
    .i_funct3     (bus.i_funct3),
    .i_opcodeB5   (bus.i_opcode[5]),
    .i_funct7b5   (bus.i_funct7b5),
    .o_aluControl (aluControl)
  );

  assign bus.o_pcWrite    = pcUpdate | (branch & bus.i_zero);
  assign bus.o_adrSrc     = adrSrc;
  assign bus.o_memWrite   = memWrite;
  assign bus.o_irWrite    = irWrite;
  assign bus.o_resultSrc  = resultSrc;
  assign bus.o_aluSrcA    = aluSrcA;
  assign bus.o_aluSrcB    = aluSrcB;
  assign bus.o_immSrc     = immSrc;
  assign bus.o_aluControl = aluControl;
  assign bus.o_regWrite   = regWrite;
  assign bus.o_illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for the multicycle main controller. Each instruction pushes
// the expected per-cycle output vector into a queue; the queue is then
// drained one cycle at a time and compared against the DUT outputs.
// Vector layout: {pcWrite, adrSrc, memWrite, irWrite, resultSrc[1:0],
//                 aluSrcA[1:0], aluSrcB[1:0], immSrc[1:0], aluControl[2:0],
//                 regWrite, illegal}
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {bus.o_pcWrite, bus.o_adrSrc, bus.o_memWrite,
                     bus.o_irWrite, bus.o_resultSrc, bus.o_aluSrcA,
                     bus.o_aluSrcB, bus.o_immSrc, bus.o_aluControl,
                     bus.o_regWrite, bus.o_illegal};

  function automatic logic [16:0] vec(
    input logic pcW, input logic adr, input logic memW, input logic irW,
    input logic [1:0] res, input logic [1:0] srcA, input logic [1:0] srcB,
    input logic [1:0] imm, input logic [2:0] alu, input logic regW,
    input logic ill);
    return {pcW, adr, memW, irW, res, srcA, srcB, imm, alu, regW, ill};
  endfunction

  function automatic void pushExp(input string tag, input logic [16:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endfunction

  // Drive one instruction's fields (held for its whole duration) and queue
  // the expected output of every cycle from FETCH to its last state.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z,
                               input logic [2:0] expAlu, input string name);
    logic [1:0]  imm;
    logic [16:0] decodeVec;
    bus.i_opcode   = op;
    bus.i_funct3   = f3;
    bus.i_funct7b5 = f7;
    bus.i_zero     = z;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    decodeVec = vec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    pushExp({name, ".fetch"}, vec(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0));
    case (op)
      7'b0000011: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".memadr"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0));
        pushExp({name, ".memread"}, vec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0));
        pushExp({name, ".memwb"}, vec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1, 0));
      end
      7'b0100011: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".memadr"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0));
        pushExp({name, ".memwrite"}, vec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0));
      end
      7'b0110011: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".executer"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, expAlu, 0, 0));
        pushExp({name, ".aluwb"}, vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0));
      end
      7'b0010011: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".executei"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, expAlu, 0, 0));
        pushExp({name, ".aluwb"}, vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0));
      end
      7'b1100011: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".beq"}, vec(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 0, 0));
      end
      7'b1101111: begin
        pushExp({name, ".decode"}, decodeVec);
        pushExp({name, ".jal"}, vec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0, 0));
        pushExp({name, ".aluwb"}, vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0));
      end
      default: begin
        pushExp({name, ".decode_illegal"}, vec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 1));
      end
    endcase
  endtask

  // Pop one expectation per cycle, compare mid-cycle on the falling edge,
  // then step to just after the next rising edge.
  task automatic checkOutput();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("[TB] FAIL %s observed=%05h expected=%05h", e.tag, obs, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_opcode   = 7'b0100011;
    bus.i_funct3   = 3'b010;
    bus.i_funct7b5 = 1'b1;
    bus.i_zero     = 1'b1;

    $display("[TB] reset held for 3 cycles");
    for (int i = 0; i < 3; i++) pushExp("reset", 17'h0);
    checkOutput();
    rst = 1'b0;

    $display("[TB] instruction sequence");
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, "lw");
    checkOutput();
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b1, 3'b000, "sw");
    checkOutput();
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, "sub");
    checkOutput();
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, "add");
    checkOutput();
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, "and");
    checkOutput();
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, "or");
    checkOutput();
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, "slt");
    checkOutput();
    applyStimulus(7'b0110011, 3'b001, 1'b0, 1'b0, 3'b000, "sll_unsup");
    checkOutput();
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, "addi_b30");
    checkOutput();
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011, "ori");
    checkOutput();
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000, "beq_taken");
    checkOutput();
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000, "beq_not");
    checkOutput();
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, "jal");
    checkOutput();
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 3'b000, "illegal");
    checkOutput();

    $display("[TB] reset during MEMWRITE");
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, "sw_abort");
    void'(sb.pop_back());
    checkOutput();
    rst = 1'b1;
    pushExp("rst_memwrite", 17'h0);
    checkOutput();
    rst = 1'b0;

    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, "sub_after_rst");
    checkOutput();
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, "lw_final");
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
